jk_decoder: RTL and testbench
=============================

JK_DECODER -- requirements
Module: jk_decoder

Interface
REQ-001 SHALL: clk48  input  1  48 MHz clock (4 clocks per full-speed bit); all logic on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: dp  input  1  D+ line level, already synchronized to clk48 externally.
REQ-004 SHALL: dn  input  1  D- line level, already synchronized to clk48 externally.
REQ-005 SHALL: bit_out  output  1  decoded, destuffed payload bit; meaningful only while bit_valid=1.
REQ-006 SHALL: bit_valid  output  1  one-cycle strobe per payload bit delivered.
REQ-007 SHALL: active  output  1  high from SYNC acceptance until eop or rx_error.
REQ-008 SHALL: eop  output  1  one-cycle pulse on a valid end-of-packet.
REQ-009 SHALL: rx_error  output  1  one-cycle pulse on any framing, stuffing or line error.
REQ-010 SHALL: bus_reset  output  1  level; high while SE0 is held long enough to be a USB reset (see Configuration).

Function
REQ-011 SHALL: line symbols are decoded as J={dp,dn}=10, K=01, SE0=00, SE1=11.
REQ-012 SHALL: an edge is a cycle where {dp,dn} differs from its value in the previous cycle; on an edge, phase <= 1, else phase <= phase+1 mod 4.
REQ-013 SHALL: the line is sampled in the cycle with phase==2, so a transition first visible at edge t is sampled at t+2.
REQ-014 SHALL: NRZI decode of a J/K sample is 1 if equal to the previous J/K sample, else 0; the previous symbol is J in IDLE.
REQ-015 SHALL: bit_out/bit_valid are registered and asserted in the cycle after the sample (t+3); bit_valid is never high for two consecutive cycles.
REQ-016 SHALL: states IDLE, SYNC, PAYLOAD, EOP, ERROR; transitions are evaluated only on sample cycles.
REQ-017 SHALL: IDLE: a K sample sets zero_count=1 and moves to SYNC; SE0 or J samples stay in IDLE; an SE1 sample moves to ERROR.
REQ-018 SHALL: SYNC: a decoded 0 increments zero_count (saturates at 7); a decoded 1 with zero_count>=5 moves to PAYLOAD and asserts active; a decoded 1 with zero_count<5, or an SE0/SE1 sample, pulses rx_error and moves to ERROR.
REQ-019 SHALL: PAYLOAD: the ones counter (3 bits) increments on each decoded 1 and clears on each decoded 0; decoded bits are delivered via bit_valid.
REQ-020 SHALL: PAYLOAD: after six consecutive 1s, the next bit is the stuff bit and is discarded (no bit_valid); a 0 clears the counter; a 1 pulses rx_error and moves to ERROR.
REQ-021 SHALL: PAYLOAD: an SE0 sample moves to EOP with se0_count=1 and produces no bit_valid; an SE1 sample pulses rx_error and moves to ERROR.
REQ-022 SHALL: EOP: each SE0 sample increments se0_count; a J sample with se0_count in {1,2} pulses eop, deasserts active and moves to IDLE; a K sample, an SE1 sample, or se0_count reaching 3 pulses rx_error and moves to ERROR.
REQ-023 SHALL: ERROR: active=0 and bit_valid=0; return to IDLE after 8 consecutive J samples; any non-J sample restarts that count.
REQ-024 SHALL: eop and rx_error are mutually exclusive in any cycle, and each deasserts active in the same cycle it asserts.

Reset
REQ-025 SHALL: reset holds state=IDLE, phase=0, previous symbol=J, and all counters at 0.
REQ-026 SHALL: while reset is high, and in the first cycle after it falls, bit_out, bit_valid, active, eop, rx_error and bus_reset are all 0.
REQ-027 SHALL: reset asserted mid-packet aborts the packet silently (no eop or rx_error pulse); the decoder resynchronizes on the next K after release.

Configuration
REQ-028 SHALL: macro JK_DECODER_BUS_RESET_EN defined: a 7-bit counter counts consecutive clk48 cycles with SE0, independent of state, and clears on any non-SE0 cycle.
REQ-029 SHALL: with the macro defined, bus_reset is high from the cycle the counter reaches 120 (2.5 us) until the first non-SE0 cycle; the counter saturates at 120.
REQ-030 SHALL: macro not defined: bus_reset is constant 0, the counter is not present, and all other behaviour is identical.

Verification
REQ-031 SHALL: J idle, then KJKJKJKK, then 0xA5 LSB-first NRZI, then SE0 SE0 J, 4 clocks per symbol -> bit_valid pulses 4 clocks apart with bits 1,0,1,0,0,1,0,1; one eop pulse; active spans the packet.
REQ-032 SHALL: SYNC + 0xFF with the encoder-inserted stuff 0 after the 6th 1, then EOP -> 8 bit_valid pulses with bit_out=1; no pulse for the stuff bit; eop pulse; no rx_error.
REQ-033 SHALL: SYNC + seven consecutive decoded 1s -> rx_error pulse on the 7th bit's sample+1; active=0; no bit_valid until 8 J bits have been seen, after which a new packet decodes.
REQ-034 SHALL: each transition in REQ-031 displaced by +/-1 clk48 -> identical bit sequence and eop pulse.
REQ-035 SHALL: reset pulsed after the 3rd payload bit -> all outputs 0 with no eop/rx_error; the next packet decodes correctly.
REQ-036 SHALL: SE0 held for 130 cycles -> with JK_DECODER_BUS_RESET_EN, bus_reset rises at cycle 120 and falls on the first J cycle; without the macro, bus_reset stays 0.

Source files
------------

// File: rtl/jk_decoder.sv
// USB full-speed receive front end: J/K line recovery, NRZI decode, bit destuffing and EOP framing.
// Defining JK_DECODER_BUS_RESET_EN adds the SE0 bus-reset detector; otherwise bus_reset is tied 0.
module jk_decoder (
    input  logic clk48,
    input  logic reset,
    input  logic dp,
    input  logic dn,
    output logic bit_out,
    output logic bit_valid,
    output logic active,
    output logic eop,
    output logic rx_error,
    output logic bus_reset
);
    localparam logic [1:0] SymSe0 = 2'b00;
    localparam logic [1:0] SymK   = 2'b01;
    localparam logic [1:0] SymJ   = 2'b10;
    localparam logic [1:0] SymSe1 = 2'b11;

    typedef enum logic [2:0] {StIdle, StSync, StPayload, StEop, StError} state_e;

    state_e     state_q;
    logic [1:0] line;
    logic [1:0] line_q;
    logic [1:0] phase_q;
    logic       prev_j_q;
    logic [2:0] zero_cnt_q;
    logic [2:0] ones_cnt_q;
    logic [2:0] j_cnt_q;
    logic [1:0] se0_cnt_q;
    logic       bit_out_q;
    logic       bit_valid_q;
    logic       active_q;
    logic       eop_q;
    logic       rx_error_q;

    logic sample;
    logic is_j;
    logic is_k;
    logic is_jk;
    logic nrzi_bit;
    logic err_evt;

    assign line     = {dp, dn};
    assign sample   = (phase_q == 2'd2);
    assign is_j     = (line == SymJ);
    assign is_k     = (line == SymK);
    assign is_jk    = is_j | is_k;
    assign nrzi_bit = (is_j == prev_j_q);

    // Every framing, stuffing or line violation funnels through this one event.
    always_comb begin
        err_evt = 1'b0;
        if (sample) begin
            unique case (state_q)
                StIdle:    err_evt = (line == SymSe1);
                StSync:    err_evt = !is_jk || (nrzi_bit && (zero_cnt_q < 3'd5));
                StPayload: err_evt = (line == SymSe1) || (is_jk && (ones_cnt_q == 3'd6) && nrzi_bit);
                StEop:     err_evt = ((line == SymSe0) && (se0_cnt_q == 2'd2)) || is_k ||
                                     (line == SymSe1);
                default:   err_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk48) begin
        if (reset) begin
            state_q     <= StIdle;
            line_q      <= SymJ;
            phase_q     <= 2'd0;
            prev_j_q    <= 1'b1;
            zero_cnt_q  <= 3'd0;
            ones_cnt_q  <= 3'd0;
            j_cnt_q     <= 3'd0;
            se0_cnt_q   <= 2'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            active_q    <= 1'b0;
            eop_q       <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            line_q      <= line;
            phase_q     <= (line != line_q) ? 2'd1 : phase_q + 2'd1;
            bit_valid_q <= 1'b0;
            eop_q       <= 1'b0;
            rx_error_q  <= 1'b0;
            if (sample) begin
                if (is_jk) begin
                    prev_j_q <= is_j;
                end
                if (err_evt) begin
                    state_q    <= StError;
                    j_cnt_q    <= 3'd0;
                    rx_error_q <= 1'b1;
                    active_q   <= 1'b0;
                end else begin
                    case (state_q)
                        StIdle: begin
                            if (is_k) begin
                                state_q    <= StSync;
                                zero_cnt_q <= 3'd1;
                            end
                        end
                        StSync: begin
                            if (!nrzi_bit) begin
                                zero_cnt_q <= (zero_cnt_q == 3'd7) ? zero_cnt_q : zero_cnt_q + 3'd1;
                            end else begin
                                state_q    <= StPayload;
                                active_q   <= 1'b1;
                                ones_cnt_q <= 3'd0;
                            end
                        end
                        StPayload: begin
                            if (line == SymSe0) begin
                                state_q   <= StEop;
                                se0_cnt_q <= 2'd1;
                            end else if (ones_cnt_q == 3'd6) begin
                                // Stuffed zero: swallowed without a strobe.
                                ones_cnt_q <= 3'd0;
                            end else begin
                                bit_valid_q <= 1'b1;
                                bit_out_q   <= nrzi_bit;
                                ones_cnt_q  <= nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                            end
                        end
                        StEop: begin
                            if (line == SymSe0) begin
                                se0_cnt_q <= se0_cnt_q + 2'd1;
                            end else begin
                                eop_q    <= 1'b1;
                                active_q <= 1'b0;
                                state_q  <= StIdle;
                            end
                        end
                        StError: begin
                            if (is_j) begin
                                if (j_cnt_q == 3'd7) begin
                                    state_q <= StIdle;
                                end
                                j_cnt_q <= j_cnt_q + 3'd1;
                            end else begin
                                j_cnt_q <= 3'd0;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

`ifdef JK_DECODER_BUS_RESET_EN
    logic [6:0] se0_run_q;

    // 120 clk48 cycles of SE0 = 2.5 us.
    always_ff @(posedge clk48) begin
        if (reset || (line != SymSe0)) begin
            se0_run_q <= 7'd0;
        end else if (se0_run_q != 7'd120) begin
            se0_run_q <= se0_run_q + 7'd1;
        end
    end

    assign bus_reset = (se0_run_q == 7'd120);
`else
    assign bus_reset = 1'b0;
`endif

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign active    = active_q;
    assign eop       = eop_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_jk_decoder.sv
// Directed bench for jk_decoder: nominal, jittered, stuffed, error, mid-packet reset and SE0
// bus-reset cases, with hand-computed expectations.
`timescale 1ns/1ps
module tb_jk_decoder;
    localparam logic [1:0] SymSe0 = 2'b00;
    localparam logic [1:0] SymK   = 2'b01;
    localparam logic [1:0] SymJ   = 2'b10;

    logic clk48 = 1'b0;
    logic reset = 1'b1;
    logic dp    = 1'b1;
    logic dn    = 1'b0;
    logic bit_out, bit_valid, active, eop, rx_error, bus_reset;

    jk_decoder dut (
        .clk48     (clk48),
        .reset     (reset),
        .dp        (dp),
        .dn        (dn),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .active    (active),
        .eop       (eop),
        .rx_error  (rx_error),
        .bus_reset (bus_reset)
    );

    always #5 clk48 = ~clk48;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk48) cyc <= cyc + 1;

    logic       mon_bits[$];
    int         bv_cyc[$];
    logic [1:0] sym_q[$];
    int n_eop, n_err, eop_cyc, err_cyc, act_cycles, act_at_eop, act_at_err, bv_inactive;
    int busrst_cycles, br_rise, br_fall;
    int busrst_total = 0;
    int b2b          = 0;
    int both         = 0;
    logic prev_bv    = 1'b0;
    logic prev_br    = 1'b0;

    always @(negedge clk48) begin
        if (bit_valid) begin
            mon_bits.push_back(bit_out);
            bv_cyc.push_back(cyc);
            if (!active) bv_inactive++;
        end
        if (bit_valid && prev_bv) b2b++;
        prev_bv = bit_valid;
        if (active) act_cycles++;
        if (eop) begin
            n_eop++;
            eop_cyc    = cyc;
            act_at_eop = int'(active);
        end
        if (rx_error) begin
            n_err++;
            err_cyc    = cyc;
            act_at_err = int'(active);
        end
        if (eop && rx_error) both++;
        if (bus_reset) begin
            busrst_cycles++;
            busrst_total++;
            if (!prev_br) br_rise = cyc;
        end else if (prev_br) begin
            br_fall = cyc;
        end
        prev_br = bus_reset;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_mon();
        mon_bits.delete();
        bv_cyc.delete();
        n_eop = 0; n_err = 0; eop_cyc = -1; err_cyc = -1;
        act_cycles = 0; act_at_eop = -1; act_at_err = -1; bv_inactive = 0;
        busrst_cycles = 0; br_rise = -1; br_fall = -1;
    endtask

    task automatic drive(input logic [1:0] s, input int n);
        {dp, dn} = s;
        repeat (n) begin
            @(posedge clk48);
            #1;
        end
    endtask

    // SYNC (KJKJKJKK), NRZI payload LSB first, optional stuffing, then SE0 SE0 J.
    task automatic build_pkt(input logic [7:0] data, input int nbits, input bit stuff);
        logic [1:0] cur  = SymK;
        int         ones = 0;
        sym_q.delete();
        for (int i = 0; i < 8; i++) sym_q.push_back(((i % 2) == 0 || i == 7) ? SymK : SymJ);
        for (int i = 0; i < nbits; i++) begin
            if (!data[i]) cur = (cur == SymK) ? SymJ : SymK;
            sym_q.push_back(cur);
            ones = data[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                cur = (cur == SymK) ? SymJ : SymK;
                sym_q.push_back(cur);
                ones = 0;
            end
        end
        sym_q.push_back(SymSe0);
        sym_q.push_back(SymSe0);
        sym_q.push_back(SymJ);
    endtask

    // jit shifts every other symbol boundary by jit clocks.
    task automatic send_pkt(input int jit, input int idle);
        foreach (sym_q[k]) drive(sym_q[k], ((k % 2) == 0) ? 4 + jit : 4 - jit);
        drive(SymJ, idle);
    endtask

    function automatic int bits_val();
        int v = 0;
        foreach (mon_bits[i]) if (mon_bits[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int outs();
        return int'({bit_out, bit_valid, active, eop, rx_error, bus_reset});
    endfunction

    task automatic check_a5(input string tag);
        check_eq({tag, "_bits"}, (mon_bits.size() << 8) | bits_val(), (8 << 8) | 'hA5);
        check_eq({tag, "_eop"}, n_eop, 1);
        check_eq({tag, "_err"}, n_err, 0);
    endtask

    initial begin
        int bad;
        int first;
        int c0;

        clear_mon();
        {dp, dn} = SymJ;
        reset    = 1'b1;
        repeat (3) begin
            @(posedge clk48);
            #1;
        end
        check_eq("reset_outputs", outs(), 0);
        reset = 1'b0;
        @(posedge clk48);
        #1;
        check_eq("post_reset_outputs", outs(), 0);
        drive(SymJ, 20);

        // Nominal 0xA5 packet.
        clear_mon();
        build_pkt(8'hA5, 8, 1'b1);
        send_pkt(0, 40);
        check_a5("a5");
        bad = 0;
        for (int i = 1; i < bv_cyc.size(); i++) if (bv_cyc[i] - bv_cyc[i-1] != 4) bad++;
        check_eq("a5_spacing", bad, 0);
        check_eq("a5_active_len", act_cycles, 44);
        first = (bv_cyc.size() > 0) ? bv_cyc[0] : -1000;
        check_eq("a5_eop_delay", eop_cyc - first, 40);
        check_eq("a5_active_at_eop", act_at_eop, 0);
        check_eq("a5_bv_inactive", bv_inactive, 0);

        // One-clock early and late transitions.
        clear_mon();
        send_pkt(1, 40);
        check_a5("jit_late");
        clear_mon();
        send_pkt(-1, 40);
        check_a5("jit_early");

        // 0xFF with the stuffed zero after the sixth one.
        clear_mon();
        build_pkt(8'hFF, 8, 1'b1);
        send_pkt(0, 40);
        check_eq("ff_bits", (mon_bits.size() << 8) | bits_val(), (8 << 8) | 'hFF);
        check_eq("ff_eop", n_eop, 1);
        check_eq("ff_err", n_err, 0);

        // Seven ones with no stuffing, then too few J bits before the next packet.
        clear_mon();
        build_pkt(8'h7F, 7, 1'b0);
        send_pkt(0, 16);
        check_eq("stuff_err_bits", (mon_bits.size() << 8) | bits_val(), (6 << 8) | 'h3F);
        check_eq("stuff_err_count", n_err, 1);
        first = (bv_cyc.size() > 0) ? bv_cyc[bv_cyc.size()-1] : -1000;
        check_eq("stuff_err_timing", err_cyc - first, 4);
        check_eq("stuff_err_active", act_at_err, 0);
        check_eq("stuff_err_eop", n_eop, 0);
        clear_mon();
        build_pkt(8'hA5, 8, 1'b1);
        send_pkt(0, 40);
        check_eq("blocked_bits", mon_bits.size(), 0);
        check_eq("blocked_eop", n_eop + n_err, 0);
        clear_mon();
        send_pkt(0, 40);
        check_a5("recover");

        // Reset after the third payload bit.
        clear_mon();
        for (int k = 0; k < 11; k++) drive(sym_q[k], 4);
        reset    = 1'b1;
        {dp, dn} = SymJ;
        @(posedge clk48);
        #1;
        check_eq("rst_mid_outputs", outs(), 0);
        @(posedge clk48);
        #1;
        reset = 1'b0;
        @(posedge clk48);
        #1;
        check_eq("rst_release_outputs", outs(), 0);
        drive(SymJ, 40);
        check_eq("rst_mid_bits", (mon_bits.size() << 8) | bits_val(), (3 << 8) | 'h5);
        check_eq("rst_mid_pulses", n_eop + n_err, 0);
        clear_mon();
        send_pkt(0, 40);
        check_a5("rst_next");

        check_eq("busrst_before", busrst_total, 0);

        // Long SE0.
        clear_mon();
        c0 = cyc;
        drive(SymSe0, 130);
        drive(SymJ, 10);
`ifdef JK_DECODER_BUS_RESET_EN
        check_eq("busrst_rise", br_rise - c0, 120);
        check_eq("busrst_fall", br_fall - c0, 131);
        check_eq("busrst_len", busrst_cycles, 11);
`else
        check_eq("busrst_off", busrst_cycles, 0);
`endif
        check_eq("se0_pulses", n_eop + n_err, 0);

        check_eq("bv_back_to_back", b2b, 0);
        check_eq("eop_err_overlap", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
